cutoff_cv_expo: RTL and testbench
=================================

Name: cutoff_cv_expo

Overview:
- Converts a signed cutoff CV sample into the filter coefficient `g` consumed by the audio-rate lowpass/state-variable filter stage.
- Sits directly upstream of the filter's `g` input, between the CV input and the filter.
- Applies an exponential (1V/oct style, piecewise-linear 2^x) mapping, then saturation, then a per-sample slew limiter.
- Processes one sample per `sample_clk` rising edge using a small multi-cycle FSM on `clk`.

Parameters:
- `W`, 16, sample and coefficient width (signed two's complement).
- `G_MIN`, 8, coefficient at the lowest CV (u=0); also the reset value of `g_out`.
- `G_MAX`, 24576, saturation ceiling for the coefficient.
- `SLEW_MAX`, 512, max change of `g_out` per sample; 0 = slew bypass (output = target).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `sample_clk`  in  1  sample strobe level, synchronous to `clk`; a rising edge starts a conversion.
- `cv_in`  in  W  signed cutoff CV.
- `g_out`  out  W  signed coefficient to the filter `g` input, registered.
- `g_valid`  out  1  one-cycle pulse when `g_out` updates.
- `overrun`  out  1  one-cycle pulse when a sample edge arrives while busy.

Behaviour:
- **Reset (sync, active-high, any state):** `g_out`=G_MIN, slew state=G_MIN, `g_valid`=0, `overrun`=0, FSM=IDLE, edge-detect register=0. Reset mid-conversion aborts it with no output update.
- **Edge detect:** `sample_clk`=1 while registered previous=0.
- **IDLE:** on an edge, capture `u` = clamp(`cv_in` + 16384, 0, 32767) (15-bit unsigned, computed in W+2 bits), then go to MANT.
- **MANT (1 cycle):**
  - oct = u[14:11] (0..15); frac = u[10:0].
  - m = (G_MIN * (2048 + frac)) >> 11, truncating; computed at ≥ W+12 bits.
  - Load the shift counter with oct, then go to SHIFT.
- **SHIFT (one cycle per remaining octave; 0 cycles if oct=0, direct to SLEW):**
  - Each cycle: if m > (G_MAX >> 1), set m = G_MAX, clear the counter, go to SLEW.
  - Otherwise m <<= 1 and decrement the counter; go to SLEW when it reaches 0.
  - After the loop, target = min(m, G_MAX).
- **SLEW (1 cycle):**
  - If SLEW_MAX=0: cur = target.
  - Otherwise: if target > cur + SLEW_MAX, cur += SLEW_MAX; elif target < cur − SLEW_MAX, cur −= SLEW_MAX; else cur = target. Compare at W+1 bits.
  - Write `g_out` = cur, pulse `g_valid` for 1 cycle, return to IDLE.
- **Latency:** edge seen in cycle E → `g_out`/`g_valid` in cycle E+3+n, where n = SHIFT cycles taken (≤ oct, fewer if saturated early). Worst case E+18.
- **Busy:** an edge seen in any non-IDLE state is ignored; `overrun` pulses 1 cycle; the conversion in flight continues unaffected.
- **Stability:** `g_out` holds between updates; it is always within [G_MIN truncation floor, G_MAX] and never negative.
- **Simultaneous events:** an edge in the same cycle as FSM return to IDLE (SLEW→IDLE transition cycle) counts as busy → ignored plus overrun. `rst` with an edge → reset wins, no capture.

Test Plan:
1. SLEW_MAX=0, `cv_in`=−16384 (u=0) edge → `g_out`=8 with `g_valid` exactly 3 cycles after the edge cycle.
2. SLEW_MAX=0, `cv_in`=−15360 (u=1024, frac interp) → `g_out`=12 at E+3; `cv_in`=0 (u=16384, oct 8) → `g_out`=2048 at E+11.
3. SLEW_MAX=0, `cv_in`=32767 and `cv_in`=−32768 → `g_out`=24576 (saturated, early exit) and `g_out`=8 (clamped low) respectively; `g_out` never exceeds 24576.
4. SLEW_MAX=512, from reset, `cv_in`=0 on four successive edges → `g_out` sequence 520, 1032, 1544, 2048; a fifth edge holds 2048.
5. `cv_in`=0, second `sample_clk` rising edge 4 cycles after the first → `overrun`=1 for one cycle, exactly one `g_valid`, `g_out`=2048 (SLEW_MAX=0).
6. Assert `rst` for 1 cycle mid-SHIFT (oct 8 conversion) → next cycle `g_out`=8, `g_valid`=0, no later `g_valid` until a new edge; the new edge converts normally.

Source files
------------

// File: rtl/cutoff_cv_expo.sv
// Cutoff CV to filter coefficient: piecewise-linear 2^x, clamp, slew.
// One conversion per sample_clk rising edge, multi-cycle on clk.
module cutoff_cv_expo #(
  parameter int W        = 16,
  parameter int G_MIN    = 8,
  parameter int G_MAX    = 24576,
  parameter int SLEW_MAX = 512
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_clk,
  input  logic signed [W-1:0] cv_in,
  output logic [W-1:0]        g_out,
  output logic                g_valid,
  output logic                overrun
);

  typedef enum logic [1:0] {
    IDLE,
    MANT,
    SHIFT,
    SLEW
  } state_t;

  localparam logic signed [W+1:0] BIAS =
    (W+2)'(16384);
  localparam logic signed [W+1:0] UMAX =
    (W+2)'(32767);
  localparam logic [W:0] HALF =
    (W+1)'(G_MAX / 2);
  localparam logic [W:0] GMAXV =
    (W+1)'(G_MAX);
  localparam logic signed [W:0] SL =
    (W+1)'(SLEW_MAX);

  state_t state_q, state_n;

  logic          sclk_q;
  logic          edge_w;
  logic [14:0]   u_q, u_n, u_c;
  logic [W:0]    m_q, m_n;
  logic [3:0]    cnt_q, cnt_n;
  logic [W-1:0]  g_q, g_n;
  logic          vld_q, vld_n;
  logic          ovr_q, ovr_n;

  logic signed [W+1:0] sum;
  logic [W+11:0]       prod;
  logic [W:0]          tgt;
  logic signed [W:0]   tgt_s;
  logic signed [W:0]   cur_s;
  logic signed [W:0]   up_s;
  logic signed [W:0]   dn_s;

  assign edge_w  = sample_clk & ~sclk_q;
  assign g_out   = g_q;
  assign g_valid = vld_q;
  assign overrun = ovr_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  // Datapath and edge-detect registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= 1'b0;
      u_q    <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
      g_q    <= W'(G_MIN);
      vld_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      sclk_q <= sample_clk;
      u_q    <= u_n;
      m_q    <= m_n;
      cnt_q  <= cnt_n;
      g_q    <= g_n;
      vld_q  <= vld_n;
      ovr_q  <= ovr_n;
    end
  end

  // Next-state, exponential mapping, saturation and slew
  always_comb begin
    state_n = state_q;
    u_n     = u_q;
    m_n     = m_q;
    cnt_n   = cnt_q;
    g_n     = g_q;
    vld_n   = 1'b0;
    ovr_n   = edge_w && (state_q != IDLE);

    sum = $signed({{2{cv_in[W-1]}}, cv_in})
        + BIAS;
    if (sum[W+1])
      u_c = '0;
    else if (sum > UMAX)
      u_c = 15'h7fff;
    else
      u_c = sum[14:0];

    prod = (W+12)'(G_MIN)
         * {{W{1'b0}}, 1'b1, u_q[10:0]};

    tgt   = (m_q > GMAXV) ? GMAXV : m_q;
    tgt_s = $signed(tgt);
    cur_s = $signed({1'b0, g_q});
    up_s  = cur_s + SL;
    dn_s  = cur_s - SL;

    unique case (state_q)
      IDLE: begin
        if (edge_w) begin
          u_n     = u_c;
          state_n = MANT;
        end
      end
      MANT: begin
        m_n     = (W+1)'(prod >> 11);
        cnt_n   = u_q[14:11];
        state_n = (u_q[14:11] == 4'd0)
                ? SLEW : SHIFT;
      end
      SHIFT: begin
        if (m_q > HALF) begin
          m_n     = GMAXV;
          cnt_n   = 4'd0;
          state_n = SLEW;
        end else begin
          m_n   = m_q << 1;
          cnt_n = cnt_q - 4'd1;
          if (cnt_q == 4'd1)
            state_n = SLEW;
        end
      end
      SLEW: begin
        if (SLEW_MAX == 0)
          g_n = W'(tgt);
        else if (tgt_s > up_s)
          g_n = W'(up_s);
        else if (tgt_s < dn_s)
          g_n = W'(dn_s);
        else
          g_n = W'(tgt);
        vld_n   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cutoff_cv_expo.sv
// Directed bench for cutoff_cv_expo.
// Two instances: slew bypassed and SLEW_MAX=512.
module tb_cutoff_cv_expo;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sample_clk = 1'b0;
  logic signed [15:0] cv_in = '0;

  logic [15:0] g0, g1;
  logic        v0, v1, o0, o1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cutoff_cv_expo #(.SLEW_MAX(0)) d0 (
    .clk        (clk),
    .rst        (rst),
    .sample_clk (sample_clk),
    .cv_in      (cv_in),
    .g_out      (g0),
    .g_valid    (v0),
    .overrun    (o0)
  );

  cutoff_cv_expo #(.SLEW_MAX(512)) d1 (
    .clk        (clk),
    .rst        (rst),
    .sample_clk (sample_clk),
    .cv_in      (cv_in),
    .g_out      (g1),
    .g_valid    (v1),
    .overrun    (o1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input int obs,
                       input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic conv(input int sel,
                      input logic signed [15:0] cv,
                      input int exp_g,
                      input int exp_lat,
                      input string tag);
    int lat;
    lat = -1;
    cv_in = cv;
    sample_clk = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 1) sample_clk = 1'b0;
      if ((sel == 0) ? v0 : v1) begin
        lat = i;
        break;
      end
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " g"},
          (sel == 0) ? int'(g0) : int'(g1),
          exp_g);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_clk = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int nv, no, ostep;

    do_reset();
    check("reset g0", int'(g0), 8);
    check("reset g1", int'(g1), 8);
    check("reset valid", int'(v0), 0);
    check("reset overrun", int'(o0), 0);

    conv(0, -16'sd16384, 8, 3, "u0");
    conv(0, -16'sd15360, 12, 3, "frac");
    conv(0, 16'sd0, 2048, 11, "oct8");
    conv(0, 16'sd32767, 24576, 14, "sat hi");
    conv(0, -16'sd32768, 8, 3, "clamp lo");

    do_reset();
    conv(1, 16'sd0, 520, 11, "slew1");
    conv(1, 16'sd0, 1032, 11, "slew2");
    conv(1, 16'sd0, 1544, 11, "slew3");
    conv(1, 16'sd0, 2048, 11, "slew4");
    conv(1, 16'sd0, 2048, 11, "slew5");

    do_reset();
    nv = 0;
    no = 0;
    ostep = -1;
    cv_in = 16'sd0;
    sample_clk = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 1) sample_clk = 1'b0;
      if (i == 4) sample_clk = 1'b1;
      if (i == 6) sample_clk = 1'b0;
      if (v0) nv++;
      if (o0) begin
        no++;
        ostep = i;
      end
    end
    check("busy valids", nv, 1);
    check("busy overruns", no, 1);
    check("busy overrun step", ostep, 5);
    check("busy g", int'(g0), 2048);

    cv_in = 16'sd0;
    sample_clk = 1'b1;
    step();
    sample_clk = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort g", int'(g0), 8);
    check("abort valid", int'(v0), 0);
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (v0) nv++;
    end
    check("abort no valid", nv, 0);
    check("abort g hold", int'(g0), 8);
    conv(0, -16'sd15360, 12, 3, "after abort");

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
